ip_sel_ctrl: RTL and testbench

IP_SEL_CTRL -- requirements
Module: ip_sel_ctrl

---
 rtl/ip_sel_ctrl_if.sv | 28 ++
 rtl/ip_sel_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ip_sel_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ip_sel_ctrl_if.sv
// Pad-ring side bundle of the IP selection controller: raw select levels in,
// committed select, per-IP resets, pad output-enable gating and status out.
interface ip_sel_ctrl_if;
   logic [2:0] ip_sel_i;
   logic [2:0] ip_sel_o;
   logic [7:0] ip_rst_n_o;
   logic       pad_oe_en_o;
   logic       sw_busy_o;
   logic [7:0] sw_count_o;

   modport slave (
      input  ip_sel_i,
      output ip_sel_o,
      output ip_rst_n_o,
      output pad_oe_en_o,
      output sw_busy_o,
      output sw_count_o
   );

   modport master (
      output ip_sel_i,
      input  ip_sel_o,
      input  ip_rst_n_o,
      input  pad_oe_en_o,
      input  sw_busy_o,
      input  sw_count_o
   );
endinterface

// File: rtl/ip_sel_ctrl.sv
// IP selection controller: synchronizes and debounces the ip_sel pads, then
// walks a guarded DRAIN/HOLD/WAKE sequence so the pad mux only moves while every IP is in reset.
module ip_sel_ctrl #(
   parameter int unsigned DEB_CYCLES   = 16,
   parameter int unsigned GUARD_CYCLES = 8,
   parameter int unsigned RST_HOLD     = 4
) (
   input  logic          sys_clk_i,
   input  logic          rst_n,
   ip_sel_ctrl_if.slave  bus
);

   localparam logic [7:0] DEB_MAX  = 8'(DEB_CYCLES - 1);
   localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES - 1);
   localparam logic [7:0] HOLD_LD  = 8'(RST_HOLD - 1);

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      HOLD  = 3'd3,
      WAKE  = 3'd4
   } state_e;

   function automatic logic [7:0] one_hot(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

   logic [2:0] sync1_q, sync2_q, cand_q, deb_sel_q;
   logic [7:0] deb_cnt_q;
   logic       deb_valid_q;

   state_e     state_q, state_d;
   logic [7:0] dur_q, dur_d;
   logic [2:0] tgt_q, tgt_d;
   logic [2:0] sel_q, sel_d;
   logic       boot_pass_q, boot_pass_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] rst_n_q, rst_n_d;
   logic       oe_q, oe_d;
   logic       busy_q, busy_d;

   // Synchronizer and debouncer; deb_sel only moves after DEB_CYCLES stable samples.
   always_ff @(posedge sys_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 3'd0;
         sync2_q     <= 3'd0;
         cand_q      <= 3'd0;
         deb_cnt_q   <= 8'd0;
         deb_sel_q   <= 3'd0;
         deb_valid_q <= 1'b0;
      end else begin
         sync1_q <= bus.ip_sel_i;
         sync2_q <= sync1_q;
         if (sync2_q != cand_q) begin
            cand_q    <= sync2_q;
            deb_cnt_q <= 8'd0;
         end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_q <= deb_cnt_q + 8'd1;
         end
         if (deb_cnt_q == DEB_MAX) begin
            deb_sel_q   <= cand_q;
            deb_valid_q <= 1'b1;
         end
      end
   end

   // Next-state logic; outputs are decoded from the next state so they register in step with it.
   always_comb begin
      state_d     = state_q;
      dur_d       = dur_q;
      tgt_d       = tgt_q;
      sel_d       = sel_q;
      boot_pass_d = boot_pass_q;
      cnt_d       = cnt_q;
      case (state_q)
         BOOT: begin
            if (deb_valid_q) begin
               tgt_d       = deb_sel_q;
               sel_d       = deb_sel_q;
               boot_pass_d = 1'b1;
               dur_d       = HOLD_LD;
               state_d     = HOLD;
            end else begin
               state_d = BOOT;
            end
         end
         RUN: begin
            if (deb_valid_q && (deb_sel_q != sel_q)) begin
               tgt_d       = deb_sel_q;
               boot_pass_d = 1'b0;
               dur_d       = GUARD_LD;
               state_d     = DRAIN;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            if (dur_q == 8'd0) begin
               sel_d   = tgt_q;
               dur_d   = HOLD_LD;
               state_d = HOLD;
            end else begin
               dur_d = dur_q - 8'd1;
            end
         end
         HOLD: begin
            if (dur_q == 8'd0) begin
               dur_d   = GUARD_LD;
               state_d = WAKE;
            end else begin
               dur_d = dur_q - 8'd1;
            end
         end
         WAKE: begin
            if (dur_q == 8'd0) begin
               dur_d   = 8'd0;
               state_d = RUN;
               if (!boot_pass_q && (cnt_q != 8'hFF)) begin
                  cnt_d = cnt_q + 8'd1;
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
               dur_d = dur_q - 8'd1;
            end
         end
         default: begin
            dur_d   = 8'd0;
            state_d = BOOT;
         end
      endcase

      oe_d   = (state_d == RUN);
      busy_d = (state_d != RUN);
      case (state_d)
         BOOT, HOLD: rst_n_d = 8'h00;
         default:    rst_n_d = one_hot(sel_d);
      endcase
   end

   // State, shared duration counter and registered outputs.
   always_ff @(posedge sys_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         dur_q       <= 8'd0;
         tgt_q       <= 3'd0;
         sel_q       <= 3'd0;
         boot_pass_q <= 1'b0;
         cnt_q       <= 8'd0;
         rst_n_q     <= 8'h00;
         oe_q        <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         dur_q       <= dur_d;
         tgt_q       <= tgt_d;
         sel_q       <= sel_d;
         boot_pass_q <= boot_pass_d;
         cnt_q       <= cnt_d;
         rst_n_q     <= rst_n_d;
         oe_q        <= oe_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ip_sel_o    = sel_q;
   assign bus.ip_rst_n_o  = rst_n_q;
   assign bus.pad_oe_en_o = oe_q;
   assign bus.sw_busy_o   = busy_q;
   assign bus.sw_count_o  = cnt_q;

endmodule

// File: tb/tb_ip_sel_ctrl.sv
// Directed bench for ip_sel_ctrl: table of settled switch vectors plus
// hand sequences for phase lengths, glitch rejection, sweeps, mid-switch changes and reset.
module tb_ip_sel_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   viol = 0;
   logic [2:0] prev_sel = 3'd0;

   ip_sel_ctrl_if bus_if();

   ip_sel_ctrl dut (
      .sys_clk_i (clk),
      .rst_n     (rst_n),
      .bus       (bus_if.slave)
   );

   always #20 clk = ~clk;

   typedef struct {
      logic [2:0] sel;
      logic [2:0] exp_sel;
      logic [7:0] exp_rst;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Safety monitor: oe only in RUN, select moves only with oe low and all IPs in reset.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.pad_oe_en_o && bus_if.sw_busy_o) viol++;
         if ((bus_if.ip_sel_o != prev_sel) &&
             ((bus_if.ip_rst_n_o != 8'h00) || bus_if.pad_oe_en_o)) viol++;
      end
      prev_sel = bus_if.ip_sel_o;
   end

   initial begin
      int drain_c, hold_c, wake_c, cnt0;
      logic seen, found;

      vecs[0] = '{sel: 3'd7, exp_sel: 3'd7, exp_rst: 8'h80, exp_cnt: 8'd2};
      vecs[1] = '{sel: 3'd7, exp_sel: 3'd7, exp_rst: 8'h80, exp_cnt: 8'd2};
      vecs[2] = '{sel: 3'd3, exp_sel: 3'd3, exp_rst: 8'h08, exp_cnt: 8'd3};
      vecs[3] = '{sel: 3'd0, exp_sel: 3'd0, exp_rst: 8'h01, exp_cnt: 8'd4};

      bus_if.ip_sel_i = 3'b000;
      #5 rst_n = 1'b0;
      #30;
      check("rst_sel",   8'(bus_if.ip_sel_o), 8'd0);
      check("rst_rstn",  bus_if.ip_rst_n_o, 8'h00);
      check("rst_oe",    8'(bus_if.pad_oe_en_o), 8'd0);
      check("rst_busy",  8'(bus_if.sw_busy_o), 8'd1);
      check("rst_cnt",   bus_if.sw_count_o, 8'd0);

      @(negedge clk) rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check("boot_sel",  8'(bus_if.ip_sel_o), 8'd0);
      check("boot_rstn", bus_if.ip_rst_n_o, 8'h01);
      check("boot_oe",   8'(bus_if.pad_oe_en_o), 8'd1);
      check("boot_busy", 8'(bus_if.sw_busy_o), 8'd0);
      check("boot_cnt",  bus_if.sw_count_o, 8'd0);

      // 0 -> 1 switch with per-phase cycle counts
      bus_if.ip_sel_i = 3'b001;
      drain_c = 0; hold_c = 0; wake_c = 0; seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus_if.sw_busy_o) begin
            seen = 1'b1;
            if (bus_if.ip_rst_n_o == 8'h01 && !bus_if.pad_oe_en_o) drain_c++;
            else if (bus_if.ip_rst_n_o == 8'h00 && bus_if.ip_sel_o == 3'd1) hold_c++;
            else if (bus_if.ip_rst_n_o == 8'h02 && !bus_if.pad_oe_en_o) wake_c++;
         end else if (seen) begin
            break;
         end
      end
      check("drain_len", 8'(drain_c), 8'd8);
      check("hold_len",  8'(hold_c), 8'd4);
      check("wake_len",  8'(wake_c), 8'd8);
      check("sw1_sel",   8'(bus_if.ip_sel_o), 8'd1);
      check("sw1_rstn",  bus_if.ip_rst_n_o, 8'h02);
      check("sw1_oe",    8'(bus_if.pad_oe_en_o), 8'd1);
      check("sw1_cnt",   bus_if.sw_count_o, 8'd1);

      // 10-cycle glitch must be rejected
      bus_if.ip_sel_i = 3'b100;
      repeat (10) @(negedge clk);
      bus_if.ip_sel_i = 3'b001;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (bus_if.sw_busy_o) seen = 1'b1;
      end
      check("pulse_busy", 8'(seen), 8'd0);
      check("pulse_sel",  8'(bus_if.ip_sel_o), 8'd1);
      check("pulse_cnt",  bus_if.sw_count_o, 8'd1);

      for (int v = 0; v < 4; v++) begin
         bus_if.ip_sel_i = vecs[v].sel;
         repeat (80) @(negedge clk);
         check($sformatf("vec%0d_sel", v),  8'(bus_if.ip_sel_o), 8'(vecs[v].exp_sel));
         check($sformatf("vec%0d_rstn", v), bus_if.ip_rst_n_o, vecs[v].exp_rst);
         check($sformatf("vec%0d_oe", v),   8'(bus_if.pad_oe_en_o), 8'd1);
         check($sformatf("vec%0d_cnt", v),  bus_if.sw_count_o, vecs[v].exp_cnt);
      end

      // Sweep with 25-cycle (1000 ns) dwell
      cnt0 = int'(bus_if.sw_count_o);
      bus_if.ip_sel_i = 3'b001; repeat (25) @(negedge clk);
      bus_if.ip_sel_i = 3'b010; repeat (25) @(negedge clk);
      bus_if.ip_sel_i = 3'b100; repeat (25) @(negedge clk);
      bus_if.ip_sel_i = 3'b000; repeat (150) @(negedge clk);
      check("sweep_cnt",  bus_if.sw_count_o, 8'(cnt0 + 4));
      check("sweep_rstn", bus_if.ip_rst_n_o, 8'h01);
      check("sweep_sel",  8'(bus_if.ip_sel_o), 8'd0);

      // New code arriving during HOLD of a 0->1 switch
      cnt0 = int'(bus_if.sw_count_o);
      bus_if.ip_sel_i = 3'b001;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus_if.sw_busy_o && bus_if.ip_rst_n_o == 8'h00) begin
            found = 1'b1;
            break;
         end
      end
      check("hold_found", 8'(found), 8'd1);
      bus_if.ip_sel_i = 3'b010;
      repeat (150) @(negedge clk);
      check("holdchg_sel", 8'(bus_if.ip_sel_o), 8'd2);
      check("holdchg_cnt", bus_if.sw_count_o, 8'(cnt0 + 2));

      // Reset asserted in WAKE of a 2->5 switch
      bus_if.ip_sel_i = 3'b101;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus_if.sw_busy_o && bus_if.ip_rst_n_o == 8'h20) begin
            found = 1'b1;
            break;
         end
      end
      check("wake_found", 8'(found), 8'd1);
      #1 rst_n = 1'b0;
      #1;
      check("wrst_sel",  8'(bus_if.ip_sel_o), 8'd0);
      check("wrst_rstn", bus_if.ip_rst_n_o, 8'h00);
      check("wrst_oe",   8'(bus_if.pad_oe_en_o), 8'd0);
      check("wrst_busy", 8'(bus_if.sw_busy_o), 8'd1);
      check("wrst_cnt",  bus_if.sw_count_o, 8'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (150) @(negedge clk);
      check("reboot_sel",  8'(bus_if.ip_sel_o), 8'd5);
      check("reboot_rstn", bus_if.ip_rst_n_o, 8'h20);
      check("reboot_oe",   8'(bus_if.pad_oe_en_o), 8'd1);
      check("reboot_cnt",  bus_if.sw_count_o, 8'd0);

      check("safety_viol", 8'(viol), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
